// File: rtl/tennis_rally_engine.sv
`default_nettype none
// ============================================================================
// Module   : tennis_rally_engine
// Purpose  : Self-timed tennis rally engine. It moves a one-hot ball across
//            NUM_LEDS positions, judges hits and misses, keeps score, detects
//            the winner and supports a single-player squash mode against a
//            wall at the NUM_LEDS-1 end.
// Ports    : clk, reset (async, active-high)
//            hits[1:0]   debounced button levels, bit p = player p
//            squash      single-player mode select, sampled at serve
//            leds        ball one-hot / all-on point flash / winner half
//            score0/1    scores (squash: returns / misses)
//            ball_period current clk cycles per ball step
//            game_over, winner
// Options  : DEUCE_EN - two-player game also requires a two-point lead
// Revision : 1.0 - initial release
// ============================================================================
module tennis_rally_engine #(
  parameter int NUM_LEDS     = 16,
  parameter int START_PERIOD = 50000000,
  parameter int MIN_PERIOD   = 5000000,
  parameter int SPEEDUP_STEP = 5000000,
  parameter int HIT_WINDOW   = 2,
  parameter int WIN_SCORE    = 7,
  parameter int POINT_CYCLES = 25000000,
  parameter int SCORE_W      = 8
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [1:0]          hits,
  input  logic                squash,
  output logic [NUM_LEDS-1:0] leds,
  output logic [SCORE_W-1:0]  score0,
  output logic [SCORE_W-1:0]  score1,
  output logic [31:0]         ball_period,
  output logic                game_over,
  output logic                winner
);

  localparam int POS_W = $clog2(NUM_LEDS);
  localparam logic [POS_W-1:0]   LAST_POS     = POS_W'(NUM_LEDS - 1);
  localparam logic [POS_W-1:0]   P0_WIN_END   = POS_W'(HIT_WINDOW);
  localparam logic [POS_W-1:0]   P1_WIN_START = POS_W'(NUM_LEDS - HIT_WINDOW);
  localparam logic [31:0]        START_C      = 32'(START_PERIOD);
  localparam logic [31:0]        MIN_C        = 32'(MIN_PERIOD);
  localparam logic [31:0]        STEP_C       = 32'(SPEEDUP_STEP);
  localparam logic [31:0]        POINT_LAST   = 32'(POINT_CYCLES - 1);
  localparam logic [SCORE_W-1:0] SCORE_MAX    = '1;
  localparam logic [SCORE_W-1:0] WIN_S        = SCORE_W'(WIN_SCORE);
  localparam logic [SCORE_W:0]   WIN_EXT      = (SCORE_W+1)'(WIN_SCORE);
`ifdef DEUCE_EN
  localparam logic [SCORE_W:0]   LEAD_2       = (SCORE_W+1)'(2);
`endif

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_UP      = 3'd1,
    S_DOWN    = 3'd2,
    S_POINT   = 3'd3,
    S_OVER    = 3'd4
  } state_t;

  state_t             state, state_n;
  logic               server, server_n;
  logic [POS_W-1:0]   pos, pos_n;
  logic [SCORE_W-1:0] score0_n, score1_n;
  logic [31:0]        period_n;
  logic [31:0]        step_cnt, step_cnt_n;
  logic [31:0]        point_cnt, point_cnt_n;
  logic [1:0]         hits_prev;
  logic               mode_q, mode_n;
  logic               point_to, point_to_n;   // who scored the current point
  logic               winner_n;

  logic [1:0]         hit_edge;
  logic               tick;
  logic               point_done;
  logic [31:0]        faster;
  logic               do_hit, do_point, point_for;
  logic [SCORE_W:0]   scorer_ext;
  logic               two_win;

  function automatic logic [SCORE_W-1:0] sat_inc(input logic [SCORE_W-1:0] v);
    return (v == SCORE_MAX) ? v : v + 1'b1;
  endfunction

  assign hit_edge   = hits & ~hits_prev;
  assign tick       = (step_cnt >= ball_period - 32'd1);
  assign point_done = (point_cnt >= POINT_LAST);
  // Speed-up saturates at the floor without underflowing.
  assign faster     = (ball_period > MIN_C + STEP_C) ? ball_period - STEP_C : MIN_C;
  assign game_over  = (state == S_OVER);

  // Two-player win test for whoever just scored.
  always_comb begin
    scorer_ext = point_to ? {1'b0, score1} : {1'b0, score0};
`ifdef DEUCE_EN
    two_win = (scorer_ext >= WIN_EXT) &&
              (scorer_ext >= (point_to ? {1'b0, score0} : {1'b0, score1}) + LEAD_2);
`else
    two_win = (scorer_ext >= WIN_EXT);
`endif
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= S_IDLE;
      server      <= 1'b0;
      pos         <= '0;
      score0      <= '0;
      score1      <= '0;
      ball_period <= START_C;
      step_cnt    <= '0;
      point_cnt   <= '0;
      hits_prev   <= 2'b00;
      mode_q      <= 1'b0;
      point_to    <= 1'b0;
      winner      <= 1'b0;
    end else begin
      state       <= state_n;
      server      <= server_n;
      pos         <= pos_n;
      score0      <= score0_n;
      score1      <= score1_n;
      ball_period <= period_n;
      step_cnt    <= step_cnt_n;
      point_cnt   <= point_cnt_n;
      hits_prev   <= hits;
      mode_q      <= mode_n;
      point_to    <= point_to_n;
      winner      <= winner_n;
    end
  end

  always_comb begin
    state_n     = state;
    server_n    = server;
    pos_n       = pos;
    score0_n    = score0;
    score1_n    = score1;
    period_n    = ball_period;
    step_cnt_n  = tick ? '0 : step_cnt + 32'd1;
    // Counts only while flashing, so it is zero on entry to POINT.
    point_cnt_n = (state == S_POINT) ? point_cnt + 32'd1 : '0;
    mode_n      = mode_q;
    point_to_n  = point_to;
    winner_n    = winner;
    do_hit      = 1'b0;
    do_point    = 1'b0;
    point_for   = 1'b0;

    case (state)
      S_IDLE: begin
        if (hit_edge[server]) begin
          mode_n     = squash;
          period_n   = START_C;
          step_cnt_n = '0;
          state_n    = server ? S_DOWN : S_UP;
        end
      end

      S_UP: begin
        if (mode_q) begin
          // Wall end: the tick there turns the ball round in place.
          if (tick) begin
            if (pos == LAST_POS) state_n = S_DOWN;
            else                 pos_n   = pos + 1'b1;
          end
        end else if (hit_edge[1]) begin
          if (pos >= P1_WIN_START) begin
            do_hit  = 1'b1;
            state_n = S_DOWN;
          end else begin
            do_point  = 1'b1;
            point_for = 1'b0;
          end
        end else if (tick) begin
          if (pos == LAST_POS) begin
            do_point  = 1'b1;
            point_for = 1'b0;
          end else begin
            pos_n = pos + 1'b1;
          end
        end
      end

      S_DOWN: begin
        // Player 0 is the receiver in both modes; a hit outranks a tick.
        if (hit_edge[0]) begin
          if (pos < P0_WIN_END) begin
            do_hit  = 1'b1;
            state_n = S_UP;
            if (mode_q) score0_n = sat_inc(score0);
          end else begin
            do_point  = 1'b1;
            point_for = 1'b1;
          end
        end else if (tick) begin
          if (pos == '0) begin
            do_point  = 1'b1;
            point_for = 1'b1;
          end else begin
            pos_n = pos - 1'b1;
          end
        end
      end

      S_POINT: begin
        if (point_done) begin
          if (mode_q ? (score1 == WIN_S) : two_win) begin
            state_n  = S_OVER;
            winner_n = mode_q | point_to;
          end else begin
            state_n  = S_IDLE;
            server_n = mode_q ? 1'b0 : ~point_to;
            pos_n    = (mode_q || point_to) ? '0 : LAST_POS;
          end
        end
      end

      S_OVER: begin
        if (hit_edge[0]) begin
          state_n  = S_IDLE;
          server_n = 1'b0;
          pos_n    = '0;
          score0_n = '0;
          score1_n = '0;
          winner_n = 1'b0;
        end
      end

      default: state_n = S_IDLE;
    endcase

    if (do_hit) begin
      period_n   = faster;
      step_cnt_n = '0;
    end
    if (do_point) begin
      state_n    = S_POINT;
      point_to_n = point_for;
      if (point_for) score1_n = sat_inc(score1);
      else           score0_n = sat_inc(score0);
    end
  end

  // Display: ball one-hot, all-on during a point, winner's half at game end.
  always_comb begin
    leds = '0;
    case (state)
      S_POINT: leds = '1;
      S_OVER: begin
        for (int i = 0; i < NUM_LEDS; i++)
          leds[i] = (i < NUM_LEDS / 2) ? ~winner : winner;
      end
      default: leds[pos] = 1'b1;
    endcase
  end

endmodule
`default_nettype wire
